// File: rtl/vec_elem_serializer.sv
// Serializes a packed {vl, data} vector word into a val/rdy stream of elements, lowest index first.
// Optional sticky over-length flag on port err when VEC_SER_ERR_EN is defined.
module vec_elem_serializer #(
    parameter int ELEM_W    = 8,
    parameter int NUM_ELEMS = 4,
    parameter int VL_W      = $clog2(NUM_ELEMS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [VL_W+ELEM_W*NUM_ELEMS-1:0] recv_msg,
    input  logic                            recv_val,
    output logic                            recv_rdy,
    output logic [ELEM_W-1:0]               send_msg,
    output logic [VL_W-1:0]                 send_idx,
    output logic                            send_last,
    output logic                            send_val,
    input  logic                            send_rdy
`ifdef VEC_SER_ERR_EN
    ,
    output logic                            err
`endif
);

    localparam int DATA_W = ELEM_W * NUM_ELEMS;
    localparam int MSG_W  = VL_W + DATA_W;
    localparam logic [VL_W-1:0] MAX_VL = VL_W'(NUM_ELEMS);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [VL_W-1:0]   r_vl;
    logic [VL_W-1:0]   r_idx;

    logic [VL_W-1:0]   w_in_vl;
    logic [VL_W-1:0]   w_vl_clamped;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_shifted;
    logic              w_accept;
    logic              w_elem_hs;

    assign w_in_vl      = recv_msg[MSG_W-1 -: VL_W];
    assign w_in_data    = recv_msg[DATA_W-1:0];
    assign w_vl_clamped = (w_in_vl > MAX_VL) ? MAX_VL : w_in_vl;

    // Element outputs depend only on registered state; they simply hold while IDLE.
    assign w_shifted = r_data >> (r_idx * ELEM_W);
    assign send_msg  = w_shifted[ELEM_W-1:0];
    assign send_idx  = r_idx;
    assign send_last = (r_idx == r_vl - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        send_val    = 1'b0;
        w_elem_hs   = 1'b0;
        recv_rdy    = 1'b0;
        w_accept    = 1'b0;

        send_val  = (r_state == EMIT);
        w_elem_hs = send_val && send_rdy;
        // Accepting on the last handshake lets vectors run back to back without a bubble.
        recv_rdy  = (r_state == IDLE) || (w_elem_hs && send_last);
        w_accept  = recv_val && recv_rdy;

        if (w_accept) begin
            w_state_nxt = (w_vl_clamped != '0) ? EMIT : IDLE;
        end else if (w_elem_hs && send_last) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_vl   <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_data <= w_in_data;
            r_vl   <= w_vl_clamped;
            r_idx  <= '0;
        end else if (w_elem_hs && !send_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

`ifdef VEC_SER_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_in_vl > MAX_VL)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_vec_elem_serializer.sv
// Directed table-driven bench for vec_elem_serializer (NUM_ELEMS=4, ELEM_W=8),
// plus hand-written reset sequences.
module tb_vec_elem_serializer;

    localparam int ELEM_W    = 8;
    localparam int NUM_ELEMS = 4;
    localparam int VL_W      = 3;
    localparam int NVEC      = 24;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [VL_W+31:0]     recv_msg;
    logic                 recv_val;
    logic                 recv_rdy;
    logic [ELEM_W-1:0]    send_msg;
    logic [VL_W-1:0]      send_idx;
    logic                 send_last;
    logic                 send_val;
    logic                 send_rdy;
`ifdef VEC_SER_ERR_EN
    logic                 err;
`endif

    always #5 clk = ~clk;

    vec_elem_serializer #(
        .ELEM_W    (ELEM_W),
        .NUM_ELEMS (NUM_ELEMS),
        .VL_W      (VL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_idx  (send_idx),
        .send_last (send_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy)
`ifdef VEC_SER_ERR_EN
        ,
        .err       (err)
`endif
    );

    typedef struct {
        logic        rv;
        logic [2:0]  vl;
        logic [31:0] data;
        logic        sr;
        logic        ev;
        logic [7:0]  em;
        logic [2:0]  ei;
        logic        el;
        logic        err_rr;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // {rv, vl, data, sr, exp val, exp msg, exp idx, exp last, exp recv_rdy}
        // Basic vl=4
        tbl[0]  = '{1'b1, 3'd4, 32'h44332211, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h22, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h44, 3'd3, 1'b1, 1'b1};
        // Backpressure vl=3, send_rdy 1,0,0,1,1
        tbl[5]  = '{1'b1, 3'd3, 32'h00CCBBAA, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'hAA, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 8'hBB, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 8'hBB, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'hBB, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'hCC, 3'd2, 1'b1, 1'b1};
        // Back-to-back vl=2 then vl=1, recv_val held high
        tbl[11] = '{1'b1, 3'd2, 32'h00002211, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 3'd1, 32'h00000099, 1'b1, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'd1, 32'h00000099, 1'b1, 1'b1, 8'h22, 3'd1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h99, 3'd0, 1'b1, 1'b1};
        // vl=0 consumed silently, then vl=1
        tbl[15] = '{1'b1, 3'd0, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 3'd1, 32'h00000055, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h55, 3'd0, 1'b1, 1'b1};
        // Over-length vl=7 clamps to 4
        tbl[18] = '{1'b1, 3'd7, 32'h87654321, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h21, 3'd0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h43, 3'd1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h65, 3'd2, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b1, 8'h87, 3'd3, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_send_val",  32'(send_val),  32'd0);
        chk("rst_send_msg",  32'(send_msg),  32'd0);
        chk("rst_send_idx",  32'(send_idx),  32'd0);
        chk("rst_send_last", 32'(send_last), 32'd0);
`ifdef VEC_SER_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("rst_recv_rdy", 32'(recv_rdy), 32'd1);
        @(negedge clk);

        for (int k = 0; k < NVEC; k++) begin
            recv_val = tbl[k].rv;
            recv_msg = {tbl[k].vl, tbl[k].data};
            send_rdy = tbl[k].sr;
            #1;
            chk($sformatf("v%0d_send_val", k), 32'(send_val), 32'(tbl[k].ev));
            chk($sformatf("v%0d_recv_rdy", k), 32'(recv_rdy), 32'(tbl[k].err_rr));
            if (tbl[k].ev) begin
                chk($sformatf("v%0d_send_msg", k),  32'(send_msg),  32'(tbl[k].em));
                chk($sformatf("v%0d_send_idx", k),  32'(send_idx),  32'(tbl[k].ei));
                chk($sformatf("v%0d_send_last", k), 32'(send_last), 32'(tbl[k].el));
            end
`ifdef VEC_SER_ERR_EN
            chk($sformatf("v%0d_err", k), 32'(err), (k > 18) ? 32'd1 : 32'd0);
`endif
            @(negedge clk);
        end

        // Reset in the middle of a vector
        recv_val = 1'b1;
        recv_msg = {3'd4, 32'hA4A3A2A1};
        send_rdy = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        recv_msg = '0;
        #1;
        chk("mid_first_msg", 32'(send_msg), 32'hA1);
        @(negedge clk);
        #1;
        chk("mid_second_msg", 32'(send_msg), 32'hA2);
        reset = 1'b1;
        #1;
        chk("mid_rst_send_val", 32'(send_val), 32'd0);
        chk("mid_rst_recv_rdy", 32'(recv_rdy), 32'd1);
        chk("mid_rst_send_msg", 32'(send_msg), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_send_val",  32'(send_val),  32'd0);
        chk("post_rst_recv_rdy",  32'(recv_rdy),  32'd1);
        chk("post_rst_send_idx",  32'(send_idx),  32'd0);
        chk("post_rst_send_last", 32'(send_last), 32'd0);
`ifdef VEC_SER_ERR_EN
        chk("post_rst_err", 32'(err), 32'd0);
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", c), 32'(send_val), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_elem_serializer.md
# vec_elem_serializer

Downstream consumer of the datapath val/rdy queue. Accepts one packed vector word plus a vector length per transaction and emits its active elements one per cycle, lowest index first, on a val/rdy stream with an end-of-vector flag. It feeds the per-element lanes that sit behind the queue.

## Interface
- ELEM_W, 8: bits per element.
- NUM_ELEMS, 4: elements per packed word; must be ≥2.
- VL_W, $clog2(NUM_ELEMS+1): width of vector length field.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- recv_msg  in  VL_W+ELEM_W*NUM_ELEMS  {vl, data}; element i = data[i*ELEM_W +: ELEM_W].
- recv_val  in  1  upstream word valid.
- recv_rdy  out  1  block can accept a word this cycle.
- send_msg  out  ELEM_W  current element.
- send_idx  out  VL_W  index of current element.
- send_last  out  1  current element is the final one of the vector.
- send_val  out  1  element valid.
- send_rdy  in  1  downstream accepts element.
- err  out  1  present only with VEC_SER_ERR_EN; sticky over-length flag.

## Operation
- Registered state: mode (IDLE/EMIT), data_q, vl_q, idx.
- Reset (async): mode=IDLE, data_q=0, vl_q=0, idx=0, err=0. Outputs during/after reset: send_val=0, send_msg=0, send_idx=0, send_last=0, recv_rdy=1 once reset deasserts.
- Accept = recv_val && recv_rdy. On accept: data_q←data, vl_q←min(vl, NUM_ELEMS), idx←0.
- vl clamping: vl>NUM_ELEMS treated as NUM_ELEMS.
- vl=0 on accept: word consumed, nothing emitted, mode stays/returns IDLE.
- vl≥1 on accept: mode←EMIT.
- EMIT: send_val=1, send_msg=data_q[idx*ELEM_W +: ELEM_W], send_idx=idx, send_last=(idx==vl_q-1).
- Element handshake = send_val && send_rdy. Non-last: idx←idx+1. Last: mode←IDLE unless a new word is accepted in the same cycle.
- recv_rdy = (mode==IDLE) || (send_val && send_rdy && send_last). Combinational path send_rdy→recv_rdy is intentional for back-to-back vectors.
- Simultaneous last-element handshake and accept: new word loaded, idx←0, mode per new vl; no bubble.
- send_rdy low in EMIT: all outputs held stable, idx unchanged.
- IDLE: send_val=0; send_msg/send_idx/send_last hold last values (don't-care).
- idx never exceeds vl_q-1; no wrap-around.
- Reset mid-vector: remaining elements discarded, state as above.

## Timing
- Latency: word accepted in cycle N → element 0 valid in cycle N+1.
- Throughput: one element per cycle with send_rdy held high; vector of length L occupies L cycles; back-to-back vectors with no idle cycle.
- vl=0 word: consumes one accept cycle, zero output cycles.
- Outputs are registered-state functions only (no recv→send combinational path).

## Configuration
- VEC_SER_ERR_EN defined: err port exists; set to 1 on the cycle after any accept with vl>NUM_ELEMS, stays 1 until reset. Clamping still applies.
- Not defined: no err port, no flag register; over-length vl clamps silently.

## Test plan
- Reset: assert reset mid-EMIT with NUM_ELEMS=4 → send_val=0, recv_rdy=1 after deassert; no further elements emitted.
- Basic: send {vl=4, data=0x44332211}, send_rdy=1 → elements 0x11,0x22,0x33,0x44 on cycles N+1..N+4, idx 0..3, send_last only on 0x44.
- Backpressure: vl=3, data=0x00CCBBAA, send_rdy toggled 1,0,0,1,1 → 0xBB held stable for both stall cycles; 0xCC last; recv_rdy=0 until last handshake.
- Back-to-back: vectors {2,0x....2211} and {1,0x....0099} with recv_val always 1 → stream 0x11,0x22(last),0x99(last) on three consecutive cycles, second accept on 0x22 handshake.
- vl=0 then vl=1: first word consumed without output; next word's element 0 appears one cycle after its accept.
- Over-length: vl=7 with NUM_ELEMS=4 → exactly 4 elements emitted; with VEC_SER_ERR_EN err=1 from next cycle until reset, without it no err port.
